// File: rtl/instruction_loader.sv
// -----------------------------------------------------------------------------
// instruction_loader
//   Writer side of the instruction memory. Assembles little-endian words from a
//   byte stream (first byte -> LSB) and writes them to consecutive word
//   addresses starting at 0. Stops after writing the HALT word (DONE) or after
//   filling the last address without a HALT (FULL).
//
// Ports
//   i_clk, i_reset_n      clock (rising edge), async active-low reset
//   i_start               arm/re-arm; only honoured in IDLE, DONE or FULL
//   i_byte_valid, i_byte  incoming byte, consumed when o_byte_ready is high
//   o_byte_ready          loader is in RECV and will take a byte this cycle
//   o_write_enable        one-cycle memory write strobe
//   o_address             word address of the write (holds outside WRITE)
//   o_write_data          last assembled word
//   o_busy                high in RECV and WRITE
//   o_done / o_overflow   sticky status until next i_start
//   o_timeout             one-cycle pulse when a partial word is abandoned
//   o_word_count          words written since the last i_start
//
// Build option
//   LOADER_TIMEOUT_EN     enables the inter-byte timeout; without it the loader
//                         waits indefinitely and o_timeout is tied low.
// -----------------------------------------------------------------------------
module instruction_loader #(
  parameter int                 PC_WIDTH       = 9,
  parameter int                 NB_WIDTH       = 32,
  parameter int                 NB_BYTE        = 8,
  parameter logic [NB_WIDTH-1:0] HALT_WORD     = 32'hFFFFFFFF,
  parameter int                 TIMEOUT_CYCLES = 65535
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_start,
  input  logic                i_byte_valid,
  input  logic [NB_BYTE-1:0]  i_byte,
  output logic                o_byte_ready,
  output logic                o_write_enable,
  output logic [PC_WIDTH-1:0] o_address,
  output logic [NB_WIDTH-1:0] o_write_data,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_overflow,
  output logic                o_timeout,
  output logic [PC_WIDTH:0]   o_word_count
);

  localparam int NBYTES = NB_WIDTH / NB_BYTE;
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BW-1:0]       LAST_BYTE = BW'(NBYTES - 1);
  localparam logic [PC_WIDTH-1:0] LAST_ADDR = {PC_WIDTH{1'b1}};

  if (NB_WIDTH != 4 * NB_BYTE || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("instruction_loader: NB_WIDTH must be 4*NB_BYTE and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    FULL  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   addr_q,  addr_d;
  logic [NB_WIDTH-1:0]   data_q,  data_d;
  logic [NB_WIDTH-1:0]   buf_q,   buf_d;
  logic [PC_WIDTH:0]     cnt_q,   cnt_d;
  logic [BW-1:0]         bcnt_q,  bcnt_d;
  logic                  done_q,  done_d;
  logic                  ovf_q,   ovf_d;
  logic                  ready_q, ready_d;
  logic                  we_q,    we_d;
  logic                  busy_q,  busy_d;
  logic                  accept;
  logic                  tmo_fire;

  // ready_q is only ever high while state_q == RECV
  assign accept = ready_q & i_byte_valid;

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          to_q;

  // Counts idle cycles only while a word is partially assembled.
  assign tmo_fire = (state_q == RECV) && (bcnt_q != '0) && !accept &&
                    (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tcnt_d = '0;
    if ((state_q == RECV) && (bcnt_q != '0) && !accept && !tmo_fire)
      tcnt_d = tcnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tcnt_q <= '0;
      to_q   <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      to_q   <= tmo_fire;
    end
  end

  assign o_timeout = to_q;
`else
  assign tmo_fire  = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    done_d  = done_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE, FULL: begin
        if (i_start) begin
          state_d = RECV;
          addr_d  = '0;
          cnt_d   = '0;
          bcnt_d  = '0;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      RECV: begin
        if (accept) begin
          buf_d[int'(bcnt_q)*NB_BYTE +: NB_BYTE] = i_byte;
          if (bcnt_q == LAST_BYTE) begin
            data_d  = buf_d;
            bcnt_d  = '0;
            state_d = WRITE;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end else if (tmo_fire) begin
          // abandon the partial word; address stays put
          bcnt_d = '0;
        end
      end
      WRITE: begin
        cnt_d = cnt_q + 1'b1;
        if (data_q == HALT_WORD) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (addr_q == LAST_ADDR) begin
          state_d = FULL;
          ovf_d   = 1'b1;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = RECV;
        end
      end
      default: state_d = IDLE;
    endcase

    // Strobes decoded from the next state so every output comes from a flop.
    ready_d = (state_d == RECV);
    we_d    = (state_d == WRITE);
    busy_d  = (state_d == RECV) || (state_d == WRITE);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
    end
  end

  assign o_byte_ready   = ready_q;
  assign o_write_enable = we_q;
  assign o_address      = addr_q;
  assign o_write_data   = data_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_overflow     = ovf_q;
  assign o_word_count   = cnt_q;

endmodule

// File: tb/tb_instruction_loader.sv
// -----------------------------------------------------------------------------
// tb_instruction_loader
//   Scoreboard bench: each word's expected (address, data) is queued when its
//   bytes are driven; a monitor pops and compares on every write strobe.
//   Uses PC_WIDTH=3 so the full-memory case is reachable, TIMEOUT_CYCLES=16.
// -----------------------------------------------------------------------------
module tb_instruction_loader;
  localparam int PW = 3;
  localparam int NW = 32;
  localparam int NB = 8;
  localparam int TO = 16;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_byte_valid = 1'b0;
  logic [NB-1:0] i_byte = '0;
  logic          o_byte_ready, o_write_enable, o_busy, o_done, o_overflow, o_timeout;
  logic [PW-1:0] o_address;
  logic [NW-1:0] o_write_data;
  logic [PW:0]   o_word_count;

  instruction_loader #(
    .PC_WIDTH(PW), .NB_WIDTH(NW), .NB_BYTE(NB),
    .HALT_WORD(32'hFFFFFFFF), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start),
    .i_byte_valid(i_byte_valid), .i_byte(i_byte),
    .o_byte_ready(o_byte_ready), .o_write_enable(o_write_enable),
    .o_address(o_address), .o_write_data(o_write_data),
    .o_busy(o_busy), .o_done(o_done), .o_overflow(o_overflow),
    .o_timeout(o_timeout), .o_word_count(o_word_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [PW-1:0] a;
    logic [NW-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic prev_we = 1'b0;

  // Write monitor: strobe must be single-cycle and match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (i_reset_n && o_write_enable) begin
        total_cnt++;
        if (prev_we) $display("FAIL strobe_len: write_enable high two cycles in a row, required one");
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_write: addr %0d data %h, required no write", o_address, o_write_data);
        end else begin
          e = exp_q.pop_front();
          if (o_address !== e.a || o_write_data !== e.d)
            $display("FAIL write: addr %0d data %h, required addr %0d data %h",
                     o_address, o_write_data, e.a, e.d);
          else pass_cnt++;
        end
      end
      prev_we = i_reset_n ? o_write_enable : 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation ran too long");
    $fatal(1, "global timeout");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // Called just after a negedge; returns just after the negedge following the
  // edge that consumed the byte. i_byte_valid is left high.
  task automatic send_byte(input logic [NB-1:0] b);
    int g;
    i_byte_valid = 1'b1;
    i_byte       = b;
    g = 0;
    while (!o_byte_ready && g < 100) begin
      @(negedge i_clk);
      g++;
    end
    if (g >= 100) begin
      total_cnt++;
      $display("FAIL byte_wait: byte %h never accepted, required acceptance within 100 cycles", b);
    end
    @(negedge i_clk);
  endtask

  task automatic send_word(input logic [PW-1:0] a, input logic [NW-1:0] d);
    exp_q.push_back('{a: a, d: d});
    for (int k = 0; k < 4; k++) send_byte(d[8*k +: 8]);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (!o_done && g < 100) begin
      @(negedge i_clk);
      g++;
    end
    if (g >= 100) begin
      total_cnt++;
      $display("FAIL done_wait: o_done never rose, required within 100 cycles");
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      i_start      = 1'($urandom);
      i_byte_valid = 1'($urandom);
      i_byte       = 8'($urandom);
      @(negedge i_clk);
      total_cnt++;
      if ({o_byte_ready, o_write_enable, o_address, o_write_data, o_busy,
           o_done, o_overflow, o_timeout, o_word_count} !== '0)
        $display("FAIL reset_outputs: ready %b we %b addr %0d data %h busy %b done %b ovf %b to %b cnt %0d, required all 0",
                 o_byte_ready, o_write_enable, o_address, o_write_data, o_busy,
                 o_done, o_overflow, o_timeout, o_word_count);
      else pass_cnt++;
    end
    i_start = 1'b0; i_byte_valid = 1'b0; i_byte = '0;
    i_reset_n = 1'b1;
    cyc(5);
    total_cnt++;
    if ({o_byte_ready, o_busy, o_write_enable, o_done} !== 4'b0000)
      $display("FAIL idle_after_reset: ready %b busy %b we %b done %b, required 0000",
               o_byte_ready, o_busy, o_write_enable, o_done);
    else pass_cnt++;
  endtask

  task automatic test_basic_load();
    pulse_start();
    send_word(3'd0, 32'h12345678);
    send_word(3'd1, 32'hFFFFFFFF);
    i_byte_valid = 1'b0;
    wait_done();
    cyc(1);
    total_cnt++;
    if (o_done !== 1'b1 || o_word_count !== 4'd2 || o_busy !== 1'b0 || o_byte_ready !== 1'b0)
      $display("FAIL basic_status: done %b cnt %0d busy %b ready %b, required done 1 cnt 2 busy 0 ready 0",
               o_done, o_word_count, o_busy, o_byte_ready);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    pulse_start();
    total_cnt++;
    if (o_done !== 1'b0 || o_word_count !== '0 || o_busy !== 1'b1)
      $display("FAIL restart_clear: done %b cnt %0d busy %b, required done 0 cnt 0 busy 1",
               o_done, o_word_count, o_busy);
    else pass_cnt++;
    // i_byte_valid stays high across both words and the WRITE cycle between
    send_word(3'd0, 32'h04030201);
    send_word(3'd1, 32'h08070605);
    send_word(3'd2, 32'hFFFFFFFF);
    i_byte_valid = 1'b0;
    wait_done();
    cyc(1);
    total_cnt++;
    if (o_word_count !== 4'd3 || o_address !== 3'd2)
      $display("FAIL b2b_status: cnt %0d addr %0d, required cnt 3 addr 2", o_word_count, o_address);
    else pass_cnt++;
  endtask

  task automatic test_full();
    pulse_start();
    for (int i = 0; i < 8; i++) send_word(PW'(i), 32'hA0B0C000 + 32'(i));
    // keep offering bytes: none may be consumed or written
    i_byte = 8'h55;
    cyc(10);
    total_cnt++;
    if (o_overflow !== 1'b1 || o_byte_ready !== 1'b0 || o_done !== 1'b0 ||
        o_word_count !== 4'd8 || o_busy !== 1'b0 || o_address !== 3'd7)
      $display("FAIL full_status: ovf %b ready %b done %b cnt %0d busy %b addr %0d, required ovf 1 ready 0 done 0 cnt 8 busy 0 addr 7",
               o_overflow, o_byte_ready, o_done, o_word_count, o_busy, o_address);
    else pass_cnt++;
    i_byte_valid = 1'b0;
    pulse_start();
    total_cnt++;
    if (o_overflow !== 1'b0 || o_word_count !== '0 || o_byte_ready !== 1'b1 || o_address !== '0)
      $display("FAIL full_restart: ovf %b cnt %0d ready %b addr %0d, required ovf 0 cnt 0 ready 1 addr 0",
               o_overflow, o_word_count, o_byte_ready, o_address);
    else pass_cnt++;
    send_word(3'd0, 32'hCAFEF00D);
    send_word(3'd1, 32'hFFFFFFFF);
    i_byte_valid = 1'b0;
    wait_done();
  endtask

  task automatic test_reset_mid_word();
    pulse_start();
    send_byte(8'h11);
    send_byte(8'h22);
    i_byte_valid = 1'b0;
    #2 i_reset_n = 1'b0;
    #2;
    total_cnt++;
    if ({o_byte_ready, o_write_enable, o_address, o_write_data, o_busy,
         o_done, o_overflow, o_timeout, o_word_count} !== '0)
      $display("FAIL midword_reset: ready %b addr %0d data %h busy %b done %b cnt %0d, required all 0",
               o_byte_ready, o_address, o_write_data, o_busy, o_done, o_word_count);
    else pass_cnt++;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    cyc(1);
    // start and a valid byte together: only the start is taken
    i_start = 1'b1; i_byte_valid = 1'b1; i_byte = 8'hAA;
    @(negedge i_clk);
    i_start = 1'b0;
    exp_q.push_back('{a: 3'd0, d: 32'hDDCCBBAA});
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    i_byte_valid = 1'b0;
    cyc(3);
    total_cnt++;
    if (o_word_count !== 4'd1 || o_busy !== 1'b1 || o_address !== 3'd1)
      $display("FAIL midword_resume: cnt %0d busy %b addr %0d, required cnt 1 busy 1 addr 1",
               o_word_count, o_busy, o_address);
    else pass_cnt++;
  endtask

  // Loader is in RECV at address 1 on entry.
  task automatic test_timeout();
    int pulses;
    int plen;
    pulses = 0;
    plen = 0;
`ifdef LOADER_TIMEOUT_EN
    send_byte(8'h01);
    send_byte(8'h02);
`else
    exp_q.push_back('{a: 3'd1, d: 32'h04030201});
    send_byte(8'h01);
    send_byte(8'h02);
`endif
    i_byte_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (o_timeout) plen++;
      if (o_timeout && plen == 1) pulses++;
      if (!o_timeout) plen = 0;
      @(negedge i_clk);
    end
`ifdef LOADER_TIMEOUT_EN
    total_cnt++;
    if (pulses !== 1)
      $display("FAIL timeout_pulse: %0d pulses, required 1", pulses);
    else pass_cnt++;
    total_cnt++;
    if (o_address !== 3'd1 || o_word_count !== 4'd1 || o_byte_ready !== 1'b1)
      $display("FAIL timeout_state: addr %0d cnt %0d ready %b, required addr 1 cnt 1 ready 1",
               o_address, o_word_count, o_byte_ready);
    else pass_cnt++;
    send_word(3'd1, 32'h44332211);
`else
    total_cnt++;
    if (pulses !== 0)
      $display("FAIL timeout_pulse: %0d pulses, required 0", pulses);
    else pass_cnt++;
    send_byte(8'h03);
    send_byte(8'h04);
`endif
    send_word(3'd2, 32'hFFFFFFFF);
    i_byte_valid = 1'b0;
    wait_done();
    cyc(1);
    total_cnt++;
    if (o_word_count !== 4'd3 || o_done !== 1'b1)
      $display("FAIL timeout_end: cnt %0d done %b, required cnt 3 done 1", o_word_count, o_done);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_back_to_back();
    test_full();
    test_reset_mid_word();
    test_timeout();
    cyc(3);
    total_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain: %0d writes outstanding, required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
Writer side of the pipeline's instruction memory. Takes a byte stream from the debug unit's UART receive path and assembles little-endian 32-bit words. Writes each word into consecutive instruction-memory addresses starting at 0. Stops on the HALT word or when memory is full, then reports status to the debug unit.

Parameters:
PC_WIDTH, 9, instruction-memory word-address width; DEPTH = 2**PC_WIDTH
NB_WIDTH, 32, instruction width; must be 4*NB_BYTE
NB_BYTE, 8, input byte width
HALT_WORD, 32'hFFFFFFFF, end-of-program instruction
TIMEOUT_CYCLES, 65535, inter-byte timeout; used only with LOADER_TIMEOUT_EN

Ports:
i_clk  input  1  system clock, rising edge
i_reset_n  input  1  asynchronous, active-low reset
i_start  input  1  arm the loader; honoured only in IDLE, DONE or FULL
i_byte_valid  input  1  i_byte is valid this cycle
i_byte  input  NB_BYTE  incoming program byte
o_byte_ready  output  1  loader accepts a byte this cycle
o_write_enable  output  1  one-cycle write strobe to instruction memory
o_address  output  PC_WIDTH  word address for the write
o_write_data  output  NB_WIDTH  assembled instruction
o_busy  output  1  high in RECV and WRITE
o_done  output  1  HALT word written; held until next i_start
o_overflow  output  1  memory filled without HALT; held until next i_start
o_timeout  output  1  one-cycle pulse on inter-byte timeout; constant 0 without macro
o_word_count  output  PC_WIDTH+1  words written since last i_start

Behaviour:
- One clock domain. Reset is asynchronous and active-low: i_reset_n low forces the FSM to IDLE and every output to 0, including the address, data, count and byte counter.
- All outputs are registered.
- States: IDLE, RECV, WRITE, DONE, FULL.
- IDLE: o_byte_ready=0. On i_start go to RECV; clear address, word count, byte counter, o_done and o_overflow.
- RECV: o_byte_ready=1. A byte is accepted when i_byte_valid && o_byte_ready at the edge.
  - Byte k (k=0..3) lands in bits [8k+7:8k], so the first byte received is the LSB.
  - On the 4th accepted byte: load o_write_data and go to WRITE.
  - i_byte_valid with ready low is not consumed; the source holds the byte.
- WRITE: exactly one cycle.
  - o_write_enable=1, o_byte_ready=0, o_address = current word address.
  - o_word_count increments at the end of this cycle.
  - Next state:
    - if o_write_data == HALT_WORD: go to DONE. The HALT word itself is written.
    - else if o_address == DEPTH-1: go to FULL.
    - else: o_address+1 and return to RECV.
- Latency: the 4th byte accepted at edge N gives o_write_enable high from N to N+1. The next byte can be accepted at edge N+2.
- DONE: o_done=1, o_busy=0, o_byte_ready=0. i_start restarts at address 0.
- FULL: o_overflow=1, o_byte_ready=0. No write beyond DEPTH-1 and no wrap-around. i_start restarts.
- i_start in RECV or WRITE is ignored.
- i_start and i_byte_valid asserted together in IDLE: only the start is taken; the byte is not consumed that cycle.
- Reset mid-word or mid-program: the partial word is discarded. Words already written stay in memory; the loader never clears memory.
- o_address holds its last value outside WRITE. o_write_data holds the last assembled word.

Optional Feature:
LOADER_TIMEOUT_EN
- Defined:
  - A counter runs in RECV while the byte counter is nonzero; it resets on every accepted byte.
  - When it reaches TIMEOUT_CYCLES: discard the partial word, clear the byte counter, pulse o_timeout for one cycle, and stay in RECV with o_address unchanged.
  - No timeout while waiting on a word boundary (byte counter 0).
- Undefined:
  - No counter logic; the loader waits indefinitely for the remaining bytes.
  - o_timeout is tied to 0.

Test Plan:
- Reset: hold i_reset_n=0 with random inputs -> all outputs 0, o_byte_ready=0. Release and wait 5 cycles without i_start -> still idle.
- Basic load: i_start, then bytes 78,56,34,12,FF,FF,FF,FF ->
  - 0x12345678 written at addr 0 with a single-cycle strobe;
  - 0xFFFFFFFF written at addr 1;
  - o_done=1, o_word_count=2, o_busy=0.
- Backpressure: keep i_byte_valid high continuously with bytes 01..08 -> no byte lost or duplicated across the WRITE cycle; words 0x04030201 and 0x08070605 land at addrs 0 and 1.
- Full: PC_WIDTH=3, eight non-HALT words -> writes at addrs 0..7, then o_overflow=1, no 9th strobe, o_byte_ready=0. i_start then restarts at addr 0.
- Reset mid-word: 2 bytes accepted, pulse i_reset_n low -> outputs cleared. Then i_start and bytes AA,BB,CC,DD -> 0xDDCCBBAA at addr 0.
- Timeout (macro defined, TIMEOUT_CYCLES=16): after one full word, send 2 bytes and idle 16 cycles -> one-cycle o_timeout, no write. The next 4 bytes are written at addr 1.
